// File: rtl/rt_pkg.sv
// Shared types and helpers for the result writer: FSM states, record layout
// and the 16-bit beat selector.
package rt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

  localparam int RES_NWORDS_HIT  = 3;
  localparam int RES_NWORDS_MISS = 1;

  localparam logic [2:0] LAST_BEAT_HIT  = 3'(2 * RES_NWORDS_HIT - 1);
  localparam logic [2:0] LAST_BEAT_MISS = 3'(2 * RES_NWORDS_MISS - 1);

  typedef struct packed {
    logic               hit;
    logic signed [31:0] t;
    logic [31:0]        tri_index;
  } result_t;

  // beat[2:1] picks the record word, beat[0] picks the half (low half first)
  function automatic logic [15:0] beat_half(input result_t r, input logic [2:0] beat);
    logic [31:0] word;
    case (beat[2:1])
      2'd0:    word = {31'd0, r.hit};
      2'd1:    word = r.t;
      2'd2:    word = r.tri_index;
      default: word = 32'd0;
    endcase
    beat_half = beat[0] ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/result_writer.sv
// Writes one intersection result record to SDRAM as 16-bit Avalon-MM beats.
// Optional statistics counters are enabled with `define RESULT_WRITER_STATS_EN.
module result_writer
  import rt_pkg::*;
#(
  parameter int HALF_STRIDE = 2
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_hit,
  input  logic signed [31:0] i_t,
  input  logic [31:0]        i_tri_index,
  input  logic [31:0]        i_baseaddr,
  output logic               o_done,
  output logic               avm_m0_write,
  output logic [31:0]        avm_m0_address,
  output logic [15:0]        avm_m0_writedata,
  output logic [1:0]         avm_m0_byteenable,
  input  logic               avm_m0_waitrequest
`ifdef RESULT_WRITER_STATS_EN
  ,
  output logic [31:0]        o_rec_cnt,
  output logic [31:0]        o_hit_cnt
`endif
);

  localparam logic [31:0] STRIDE = 32'(HALF_STRIDE);

  wr_state_t   state;
  wr_state_t   next_state;
  logic [2:0]  beat;
  logic [2:0]  next_beat;
  result_t     rec;
  result_t     next_rec;
  logic [31:0] base;
  logic [31:0] next_base;
  logic [2:0]  last_beat;
  logic [31:0] next_addr;
  logic [15:0] next_data;

  // Next-state logic; a beat only counts when the slave is not stalling
  always_comb begin
    next_state = state;
    next_beat  = beat;
    next_rec   = rec;
    next_base  = base;
    last_beat  = rec.hit ? LAST_BEAT_HIT : LAST_BEAT_MISS;
    case (state)
      ST_IDLE: begin
        if (i_valid) begin
          next_state = ST_WRITE;
          next_beat  = 3'd0;
          next_rec   = '{hit: i_hit, t: i_t, tri_index: i_tri_index};
          next_base  = i_baseaddr;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!avm_m0_waitrequest) begin
          next_beat = beat + 3'd1;
          if (beat == last_beat) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_WRITE;
          end
        end else begin
          next_state = ST_WRITE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    next_addr = next_base + 32'(next_beat) * STRIDE;
    next_data = beat_half(next_rec, next_beat);
  end

  // State, capture and registered bus outputs derived from the next state
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state             <= ST_IDLE;
      beat              <= 3'd0;
      rec               <= '0;
      base              <= 32'd0;
      o_ready           <= 1'b1;
      o_done            <= 1'b0;
      avm_m0_write      <= 1'b0;
      avm_m0_address    <= 32'd0;
      avm_m0_writedata  <= 16'd0;
      avm_m0_byteenable <= 2'b00;
    end else begin
      state             <= next_state;
      beat              <= next_beat;
      rec               <= next_rec;
      base              <= next_base;
      o_ready           <= (next_state == ST_IDLE);
      o_done            <= (next_state == ST_DONE);
      avm_m0_write      <= (next_state == ST_WRITE);
      avm_m0_byteenable <= (next_state == ST_WRITE) ? 2'b11 : 2'b00;
      if (next_state == ST_WRITE) begin
        avm_m0_address   <= next_addr;
        avm_m0_writedata <= next_data;
      end
    end
  end

`ifdef RESULT_WRITER_STATS_EN
  // Completed-record and hit counters, free-running with natural wrap
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_rec_cnt <= 32'd0;
      o_hit_cnt <= 32'd0;
    end else if (o_done) begin
      o_rec_cnt <= o_rec_cnt + 32'd1;
      if (rec.hit) begin
        o_hit_cnt <= o_hit_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: vector table plus beat scoreboard.
module tb_result_writer;

  logic               i_clk = 1'b0;
  logic               i_rstn;
  logic               i_valid;
  logic               o_ready;
  logic               i_hit;
  logic signed [31:0] i_t;
  logic [31:0]        i_tri_index;
  logic [31:0]        i_baseaddr;
  logic               o_done;
  logic               avm_m0_write;
  logic [31:0]        avm_m0_address;
  logic [15:0]        avm_m0_writedata;
  logic [1:0]         avm_m0_byteenable;
  logic               avm_m0_waitrequest;
`ifdef RESULT_WRITER_STATS_EN
  logic [31:0]        o_rec_cnt;
  logic [31:0]        o_hit_cnt;
`endif

  always #5 i_clk = ~i_clk;

  result_writer #(.HALF_STRIDE(2)) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .i_hit              (i_hit),
    .i_t                (i_t),
    .i_tri_index        (i_tri_index),
    .i_baseaddr         (i_baseaddr),
    .o_done             (o_done),
    .avm_m0_write       (avm_m0_write),
    .avm_m0_address     (avm_m0_address),
    .avm_m0_writedata   (avm_m0_writedata),
    .avm_m0_byteenable  (avm_m0_byteenable),
    .avm_m0_waitrequest (avm_m0_waitrequest)
`ifdef RESULT_WRITER_STATS_EN
    ,
    .o_rec_cnt          (o_rec_cnt),
    .o_hit_cnt          (o_hit_cnt)
`endif
  );

  typedef struct {
    logic        hit;
    logic [31:0] t;
    logic [31:0] idx;
    logic [31:0] base;
    int          wait_beat;
    int          wait_len;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t exp_q[$];
  vec_t  vecs[7];
  int    checks   = 0;
  int    failures = 0;
  int    rec_exp  = 0;
  int    hit_exp  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference model: record words split into low/high halves, 2-byte stride
  task automatic push_exp(input vec_t v);
    logic [31:0] w[3];
    beat_t       b;
    int          nb;
    w[0] = {31'd0, v.hit};
    w[1] = v.t;
    w[2] = v.idx;
    nb = v.hit ? 6 : 2;
    for (int k = 0; k < nb; k++) begin
      b.addr = v.base + 32'(k * 2);
      b.data = (k % 2 == 1) ? w[k / 2][31:16] : w[k / 2][15:0];
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_fields(input vec_t v);
    i_hit       = v.hit;
    i_t         = v.t;
    i_tri_index = v.idx;
    i_baseaddr  = v.base;
  endtask

  task automatic run_vec(input vec_t v, input logic hold, input vec_t nv);
    int          lat;
    int          beats;
    int          waited;
    logic        held;
    logic        got_done;
    logic [31:0] h_addr;
    logic [15:0] h_data;
    beat_t       b;
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    drive_fields(v);
    avm_m0_waitrequest = 1'b0;
    @(negedge i_clk);
    check("ready_idle", o_ready, 1);
    push_exp(v);
    lat = 0; beats = 0; waited = 0; held = 1'b0; got_done = 1'b0;
    h_addr = 32'd0; h_data = 16'd0;
    while (!got_done && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
      if (hold) begin
        i_valid = 1'b1;
        drive_fields(nv);
      end else begin
        i_valid = 1'b0;
      end
      avm_m0_waitrequest = (beats == v.wait_beat) && (waited < v.wait_len);
      if (avm_m0_waitrequest) waited++;
      @(negedge i_clk);
      check("ready_busy", o_ready, 0);
      if (held) begin
        check("hold_addr", avm_m0_address, h_addr);
        check("hold_data", avm_m0_writedata, h_data);
      end
      held = 1'b0;
      if (avm_m0_write) begin
        check("byteenable_write", avm_m0_byteenable, 2'b11);
        if (avm_m0_waitrequest) begin
          held   = 1'b1;
          h_addr = avm_m0_address;
          h_data = avm_m0_writedata;
        end else if (exp_q.size() == 0) begin
          fail_now("extra_beat");
        end else begin
          b = exp_q.pop_front();
          check("beat_addr", avm_m0_address, b.addr);
          check("beat_data", avm_m0_writedata, b.data);
          beats++;
        end
      end
      if (o_done) begin
        got_done = 1'b1;
        check("latency", lat, v.exp_lat);
        check("write_in_done", avm_m0_write, 0);
        check("byteenable_done", avm_m0_byteenable, 2'b00);
        check("beats_left", exp_q.size(), 0);
        rec_exp++;
        if (v.hit) hit_exp++;
      end
    end
    if (!got_done) fail_now("done_timeout");
    exp_q.delete();
    avm_m0_waitrequest = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    vecs[0] = '{1'b1, 32'h0001_8000, 32'd5,         32'd24,          -1, 0, 7};
    vecs[1] = '{1'b0, 32'h1234_5678, 32'd7,         32'd24,          -1, 0, 3};
    vecs[2] = '{1'b1, 32'h0001_8000, 32'd5,         32'd24,           2, 3, 10};
    vecs[3] = '{1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFFC,   -1, 0, 7};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0100,   -1, 0, 3};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'd1,         32'h0000_0040,    0, 2, 9};
    vecs[6] = '{1'b0, 32'h0, 32'h0,                 32'h0000_0200,    1, 1, 4};

    i_rstn = 1'b0; i_valid = 1'b0; avm_m0_waitrequest = 1'b0;
    i_hit = 1'b0; i_t = 32'sd0; i_tri_index = 32'd0; i_baseaddr = 32'd0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    check("rst_done", o_done, 0);
    check("rst_write", avm_m0_write, 0);
    check("rst_addr", avm_m0_address, 32'd0);
    check("rst_data", avm_m0_writedata, 16'd0);
    check("rst_be", avm_m0_byteenable, 2'b00);
    i_rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], 1'b0, vecs[i]);
    end

    // i_valid held high while a different second result waits its turn
    run_vec(vecs[0], 1'b1, vecs[3]);
    run_vec(vecs[3], 1'b0, vecs[3]);

    // Reset in the middle of a hit record, once beat 3 has been accepted
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    drive_fields(vecs[3]);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n = 0; cnt = 0;
    while (n < 4 && cnt < 20) begin
      @(negedge i_clk);
      if (avm_m0_write && !avm_m0_waitrequest) n++;
      cnt++;
      if (n < 4) begin
        @(posedge i_clk); #1;
      end
    end
    if (n < 4) fail_now("rst_seq_timeout");
    @(posedge i_clk); #1;
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    rec_exp = 0;
    hit_exp = 0;
    @(negedge i_clk);
    check("abort_write", avm_m0_write, 0);
    check("abort_done", o_done, 0);
    check("abort_ready", o_ready, 1);
    check("abort_addr", avm_m0_address, 32'd0);
    check("abort_be", avm_m0_byteenable, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("abort_quiet", {o_done, avm_m0_write}, 2'b00);
    end

    run_vec(vecs[0], 1'b0, vecs[0]);
    run_vec(vecs[1], 1'b0, vecs[1]);
    run_vec(vecs[4], 1'b0, vecs[4]);
    @(negedge i_clk);
    check("final_ready", o_ready, 1);
    @(negedge i_clk);
`ifdef RESULT_WRITER_STATS_EN
    check("rec_cnt", o_rec_cnt, rec_exp);
    check("hit_cnt", o_hit_cnt, hit_exp);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
